sha3_unpadder: RTL and testbench
================================

# sha3_unpadder

Receive-side counterpart of the SHA-3 byte padder: accepts padded rate blocks as a stream of 32-bit big-endian words, locates and strips the pad10*1 padding (0x01 … 0x80) in the final block, and re-emits only message bytes with a per-word valid-byte count. It sits after the block source in the low-throughput core's loopback/verification path, and anywhere a padded block stream must be turned back into a raw message. One block is buffered at a time; the padding scan is sequential (one byte per cycle).

## Interface
- RATE_WORDS, 18, words per rate block (18 × 32 = 576 bits); legal range 2..64
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- in  in  32  padded block word; byte 0 = in[31:24]
- in_valid  in  1  `in` valid
- in_ready  out  1  block accepts `in` this cycle
- in_last_block  in  1  sampled with the block's first word; block carries the padding
- out  out  32  message word; bytes beyond `out_bytes` forced to 0
- out_bytes  out  3  valid bytes in `out`, 0..4, MSB-first
- out_last  out  1  final word of message
- out_valid  out  1  `out`/`out_bytes`/`out_last` valid
- out_ready  in  1  downstream accepts
- pad_error  out  1  sticky: malformed padding detected in a last block

## Operation
- States: FILL, SCAN, DRAIN.
- FILL: in_ready=1; on in_valid&in_ready store `in` at word index widx, widx++; on widx==0 latch in_last_block. After word RATE_WORDS-1: go to SCAN if latched last, else DRAIN with L = 4·RATE_WORDS.
- SCAN: byte pointer p starts at B = 4·RATE_WORDS−1, one byte examined per cycle:
  - p==B: byte 0x81 → L=B, go DRAIN; byte 0x80 → p--; otherwise set pad_error, L=0, go DRAIN.
  - p<B: 0x00 → p-- (if p==0 and zero: pad_error, L=0, DRAIN); 0x01 → L=p, DRAIN; any other value → pad_error, L=0, DRAIN.
- DRAIN: emit words 0..N−1, N = ceil(L/4); word k has out_bytes=4 except the final word, which has out_bytes = L−4(N−1). out_last=1 only on the final word of a last block. L=0 in a last block → one beat: out=0, out_bytes=0, out_last=1. Non-last blocks: all RATE_WORDS words, out_bytes=4, out_last=0.
- After the final DRAIN beat is accepted: back to FILL, widx=0.
- pad_error clears only on reset.

## Timing
- Reset: state=FILL, widx=0, in_ready=1, out_valid=0, out=0, out_bytes=0, out_last=0, pad_error=0. Reset mid-block discards the buffer.
- in_ready is 1 only in FILL; it drops the cycle after the last word of a block is accepted.
- SCAN latency: B−L+1 cycles for a valid pad (1 cycle for 0x81); first out_valid is the cycle after SCAN completes. Non-last block: out_valid the cycle after the last input word.
- out_valid, out, out_bytes and out_last are registered and held stable until out_ready; one beat per cycle under continuous out_ready.
- in_ready rises the cycle after the final DRAIN handshake; there is no input/output overlap.
- in_valid is ignored outside FILL.

## Test plan
- RATE_WORDS=18, single last block, message 0x11223344 0x55 (5 bytes), byte 5=0x01, byte 71=0x80 → out 0x11223344/4/last=0, then 0x55000000/1/last=1; scan takes 67 cycles; pad_error=0.
- Last block of 71 message bytes with final byte 0x81 → 18 beats, last beat out_bytes=3, out_last=1, SCAN takes 1 cycle.
- Padding-only last block (byte 0=0x01, byte 71=0x80) → single beat out=0, out_bytes=0, out_last=1.
- Non-last block followed by last block (3-byte message 0xAABBCC) → 18 beats with out_bytes=4, out_last=0, then one beat 0xAABBCC00/3/last=1; in_ready stays 0 throughout drain.
- Malformed: last byte 0x00, or a 0x02 found during scan → pad_error=1 (sticky), single beat bytes=0, last=1; next block still processes normally.
- out_ready toggled randomly and reset asserted mid-DRAIN → outputs held stable while stalled; after reset, all outputs at their reset values and in_ready=1 the first cycle after release.

Source files
------------

// File: rtl/sha3_unpadder.sv
// rtl/sha3_unpadder.sv - strips pad10*1 padding from buffered SHA-3 rate blocks
module sha3_unpadder #(
    parameter int RATE_WORDS = 18
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_in,
    input  logic        i_in_valid,
    output logic        o_in_ready,
    input  logic        i_in_last_block,
    output logic [31:0] o_out,
    output logic [2:0]  o_out_bytes,
    output logic        o_out_last,
    output logic        o_out_valid,
    input  logic        i_out_ready,
    output logic        o_pad_error
);

    localparam int NB = 4 * RATE_WORDS;
    localparam int WW = $clog2(RATE_WORDS);
    localparam int PW = $clog2(NB);
    localparam int LW = $clog2(NB + 1);
    localparam logic [PW-1:0] P_TOP  = PW'(NB - 1);
    localparam logic [LW-1:0] L_FULL = LW'(NB);
    localparam logic [WW-1:0] W_LAST = WW'(RATE_WORDS - 1);

    typedef enum logic [1:0] {S_FILL, S_SCAN, S_DRAIN} state_t;

    typedef struct packed {
        logic [31:0] data;
        logic [2:0]  bytes;
        logic        fin;
    } beat_t;

    state_t        r_state;
    logic [31:0]   r_buf [RATE_WORDS];
    logic [WW-1:0] r_widx;
    logic [WW-1:0] r_oidx;
    logic          r_last;
    logic [PW-1:0] r_p;
    logic [LW-1:0] r_len;
    logic          r_in_ready;
    logic          r_out_valid;
    logic [31:0]   r_out;
    logic [2:0]    r_out_bytes;
    logic          r_out_last;
    logic          r_out_final;
    logic          r_pad_error;

    logic          w_in_fire;
    logic          w_out_fire;
    logic [31:0]   w_scan_word;
    logic [7:0]    w_scan_byte;
    logic          w_scan_done;
    logic          w_scan_err;
    logic [LW-1:0] w_scan_len;
    logic [WW-1:0] w_nidx;
    logic [LW-1:0] w_ld_len;
    logic [WW-1:0] w_ld_idx;
    beat_t         w_beat;

    // Beat k of an L-byte message; L==0 yields the single empty terminating beat.
    function automatic beat_t f_beat(input logic [LW-1:0] len, input logic [WW-1:0] idx,
                                     input logic [31:0] word);
        logic [LW-1:0] last_idx;
        logic [LW-1:0] rem;
        beat_t         b;
        last_idx = (len == '0) ? '0 : ((len - LW'(1)) >> 2);
        rem      = len - (last_idx << 2);
        b.fin    = (LW'(idx) == last_idx);
        b.bytes  = b.fin ? rem[2:0] : 3'd4;
        b.data   = word & ~(32'hFFFF_FFFF >> {b.bytes, 3'b000});
        return b;
    endfunction

    assign w_in_fire   = i_in_valid & r_in_ready;
    assign w_out_fire  = r_out_valid & i_out_ready;
    assign w_scan_word = r_buf[r_p[PW-1:2]];
    assign w_scan_byte = 8'(w_scan_word >> {~r_p[1:0], 3'b000});
    assign w_nidx      = r_oidx + WW'(1);

    always_comb begin
        w_scan_done = 1'b0;
        w_scan_err  = 1'b0;
        w_scan_len  = '0;
        if (r_p == P_TOP) begin
            if (w_scan_byte == 8'h81) begin
                w_scan_done = 1'b1;
                w_scan_len  = LW'(r_p);
            end else if (w_scan_byte != 8'h80) begin
                w_scan_done = 1'b1;
                w_scan_err  = 1'b1;
            end
        end else if (w_scan_byte == 8'h00) begin
            if (r_p == '0) begin
                w_scan_done = 1'b1;
                w_scan_err  = 1'b1;
            end
        end else if (w_scan_byte == 8'h01) begin
            w_scan_done = 1'b1;
            w_scan_len  = LW'(r_p);
        end else begin
            w_scan_done = 1'b1;
            w_scan_err  = 1'b1;
        end
    end

    always_comb begin
        w_ld_len = r_len;
        w_ld_idx = '0;
        case (r_state)
            S_FILL:  w_ld_len = L_FULL;
            S_SCAN:  w_ld_len = w_scan_len;
            default: w_ld_idx = w_nidx;
        endcase
        w_beat = f_beat(w_ld_len, w_ld_idx, r_buf[w_ld_idx]);
    end

    always_ff @(posedge i_clk) begin
        if (w_in_fire) begin
            r_buf[r_widx] <= i_in;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_FILL;
            r_widx      <= '0;
            r_oidx      <= '0;
            r_last      <= 1'b0;
            r_p         <= P_TOP;
            r_len       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out       <= '0;
            r_out_bytes <= '0;
            r_out_last  <= 1'b0;
            r_out_final <= 1'b0;
            r_pad_error <= 1'b0;
        end else begin
            case (r_state)
                S_FILL: begin
                    if (w_in_fire) begin
                        r_widx <= r_widx + WW'(1);
                        if (r_widx == '0) begin
                            r_last <= i_in_last_block;
                        end
                        if (r_widx == W_LAST) begin
                            r_widx     <= '0;
                            r_in_ready <= 1'b0;
                            if (r_last) begin
                                r_state <= S_SCAN;
                                r_p     <= P_TOP;
                            end else begin
                                r_state     <= S_DRAIN;
                                r_len       <= L_FULL;
                                r_oidx      <= '0;
                                r_out_valid <= 1'b1;
                                r_out       <= w_beat.data;
                                r_out_bytes <= w_beat.bytes;
                                r_out_final <= w_beat.fin;
                                r_out_last  <= 1'b0;
                            end
                        end
                    end
                end
                S_SCAN: begin
                    if (w_scan_done) begin
                        r_state     <= S_DRAIN;
                        r_len       <= w_scan_len;
                        r_pad_error <= r_pad_error | w_scan_err;
                        r_oidx      <= '0;
                        r_out_valid <= 1'b1;
                        r_out       <= w_beat.data;
                        r_out_bytes <= w_beat.bytes;
                        r_out_final <= w_beat.fin;
                        r_out_last  <= w_beat.fin & r_last;
                    end else begin
                        r_p <= r_p - PW'(1);
                    end
                end
                S_DRAIN: begin
                    if (w_out_fire) begin
                        if (r_out_final) begin
                            r_state     <= S_FILL;
                            r_in_ready  <= 1'b1;
                            r_out_valid <= 1'b0;
                            r_out       <= '0;
                            r_out_bytes <= '0;
                            r_out_last  <= 1'b0;
                            r_out_final <= 1'b0;
                        end else begin
                            r_oidx      <= w_nidx;
                            r_out       <= w_beat.data;
                            r_out_bytes <= w_beat.bytes;
                            r_out_final <= w_beat.fin;
                            r_out_last  <= w_beat.fin & r_last;
                        end
                    end
                end
                default: r_state <= S_FILL;
            endcase
        end
    end

    assign o_in_ready  = r_in_ready;
    assign o_out       = r_out;
    assign o_out_bytes = r_out_bytes;
    assign o_out_last  = r_out_last;
    assign o_out_valid = r_out_valid;
    assign o_pad_error = r_pad_error;

endmodule

// File: tb/tb_sha3_unpadder.sv
// tb/tb_sha3_unpadder.sv - randomized scoreboard bench for sha3_unpadder
module tb_sha3_unpadder;

    localparam int RW = 18;
    localparam int NB = 4 * RW;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] i_in = '0;
    logic        i_in_valid = 1'b0;
    logic        i_in_last_block = 1'b0;
    logic        i_out_ready = 1'b0;
    logic        o_in_ready;
    logic [31:0] o_out;
    logic [2:0]  o_out_bytes;
    logic        o_out_last;
    logic        o_out_valid;
    logic        o_pad_error;

    sha3_unpadder #(.RATE_WORDS(RW)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_in(i_in), .i_in_valid(i_in_valid),
        .o_in_ready(o_in_ready), .i_in_last_block(i_in_last_block),
        .o_out(o_out), .o_out_bytes(o_out_bytes), .o_out_last(o_out_last),
        .o_out_valid(o_out_valid), .i_out_ready(i_out_ready), .o_pad_error(o_pad_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic [2:0]  b;
        logic        l;
        logic        e;
    } exp_t;

    exp_t       q[$];
    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] blk [NB];
    logic       exp_err = 1'b0;

    task automatic check(input string name, input logic [39:0] got, input logic [39:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic die(input string name);
        miscompares++;
        $display("FAIL timeout %s", name);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "timeout");
    endtask

    // Monitor: picks out_ready at each falling edge and scores beats that will fire.
    initial begin
        bit          hold;
        logic [39:0] held;
        exp_t        e;
        hold = 0;
        held = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold = 0;
                i_out_ready = 1'b0;
                continue;
            end
            if (hold) begin
                check("stall_hold", {2'b0, o_out_valid, o_out, o_out_bytes, o_out_last}, held);
            end
            hold = 0;
            i_out_ready = ($urandom_range(3) != 0);
            if (o_out_valid) begin
                if (i_out_ready) begin
                    if (q.size() == 0) begin
                        check("unexpected_beat", 40'(o_out_valid), 40'(0));
                    end else begin
                        e = q.pop_front();
                        check("out_data", 40'(o_out), 40'(e.d));
                        check("out_bytes", 40'(o_out_bytes), 40'(e.b));
                        check("out_last", 40'(o_out_last), 40'(e.l));
                        check("pad_error", 40'(o_pad_error), 40'(e.e));
                    end
                end else begin
                    hold = 1;
                    held = {2'b0, o_out_valid, o_out, o_out_bytes, o_out_last};
                end
            end
        end
    end

    task automatic rand_msg(input int n);
        for (int i = 0; i < NB; i++) blk[i] = (i < n) ? 8'($urandom) : 8'h00;
    endtask

    task automatic pad(input int len);
        for (int i = len; i < NB; i++) blk[i] = 8'h00;
        if (len == NB - 1) begin
            blk[NB-1] = 8'h81;
        end else begin
            blk[len]  = 8'h01;
            blk[NB-1] = 8'h80;
        end
    endtask

    task automatic send_block(input bit last);
        int         len;
        int         cyc;
        bit         err;
        int         j;
        int         nw;
        int         guard;
        int         cnt;
        logic [31:0] d;
        len = NB;
        cyc = 0;
        err = 0;
        if (last) begin
            if (blk[NB-1] == 8'h81) begin
                len = NB - 1;
                cyc = 1;
            end else if (blk[NB-1] != 8'h80) begin
                len = 0;
                cyc = 1;
                err = 1;
            end else begin
                j = NB - 2;
                while (j >= 0 && blk[j] == 8'h00) j--;
                if (j < 0) begin
                    len = 0;
                    cyc = NB;
                    err = 1;
                end else begin
                    cyc = NB - j;
                    if (blk[j] == 8'h01) len = j;
                    else begin
                        len = 0;
                        err = 1;
                    end
                end
            end
        end
        if (err) exp_err = 1'b1;
        if (len == 0) begin
            q.push_back('{32'h0, 3'd0, 1'b1, exp_err});
        end else begin
            nw = (len + 3) / 4;
            for (int k = 0; k < nw; k++) begin
                d = '0;
                for (int i = 0; i < 4; i++)
                    if (4 * k + i < len) d[31-8*i -: 8] = blk[4*k+i];
                q.push_back('{d, 3'((len - 4 * k >= 4) ? 4 : len - 4 * k),
                              last && (k == nw - 1), exp_err});
            end
        end
        for (int w = 0; w < RW; w++) begin
            @(negedge clk);
            while ($urandom_range(4) == 0) begin
                i_in_valid = 1'b0;
                @(negedge clk);
            end
            i_in            = {blk[4*w], blk[4*w+1], blk[4*w+2], blk[4*w+3]};
            i_in_valid      = 1'b1;
            i_in_last_block = (w == 0) ? last : 1'($urandom);
            guard = 0;
            while (!o_in_ready) begin
                @(negedge clk);
                guard++;
                if (guard > 3000) die("in_ready");
            end
            @(posedge clk);
        end
        #1;
        i_in_valid = 1'b0;
        cnt = 0;
        while (!o_out_valid) begin
            @(posedge clk);
            #1;
            cnt++;
            if (cnt > 200) die("out_valid");
        end
        check(last ? "scan_latency" : "fill_latency", 40'(cnt), 40'(cyc));
    endtask

    task automatic check_reset_outputs();
        check("rst_in_ready", 40'(o_in_ready), 40'(1));
        check("rst_out_valid", 40'(o_out_valid), 40'(0));
        check("rst_out", 40'(o_out), 40'(0));
        check("rst_out_bytes", 40'(o_out_bytes), 40'(0));
        check("rst_out_last", 40'(o_out_last), 40'(0));
        check("rst_pad_error", 40'(o_pad_error), 40'(0));
    endtask

    initial begin
        int guard;
        int len;
        bit last;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs();
        @(posedge clk);
        #2 rst_n = 1'b1;

        rand_msg(5);
        {blk[0], blk[1], blk[2], blk[3], blk[4]} = 40'h11223344_55;
        pad(5);
        send_block(1);
        rand_msg(NB - 1);
        pad(NB - 1);
        send_block(1);
        pad(0);
        send_block(1);
        rand_msg(NB);
        send_block(0);
        rand_msg(3);
        {blk[0], blk[1], blk[2]} = 24'hAABBCC;
        pad(3);
        send_block(1);
        rand_msg(5);
        pad(5);
        blk[NB-1] = 8'h00;
        send_block(1);
        rand_msg(20);
        pad(20);
        blk[40] = 8'h02;
        send_block(1);
        rand_msg(9);
        pad(9);
        send_block(1);

        for (int n = 0; n < 25; n++) begin
            last = ($urandom_range(2) != 0);
            if (!last) begin
                rand_msg(NB);
            end else begin
                len = $urandom_range(0, NB - 1);
                rand_msg(len);
                pad(len);
                if ($urandom_range(4) == 0) blk[$urandom_range(len, NB - 1)] = 8'($urandom);
            end
            send_block(last);
        end

        rand_msg(NB);
        send_block(0);
        guard = 0;
        while (q.size() > 14) begin
            @(negedge clk);
            guard++;
            if (guard > 3000) die("mid_drain");
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        q.delete();
        exp_err = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs();
        rand_msg(7);
        pad(7);
        send_block(1);

        guard = 0;
        while (q.size() != 0) begin
            @(negedge clk);
            guard++;
            if (guard > 5000) die("drain_end");
        end
        repeat (3) @(negedge clk);
        check("final_in_ready", 40'(o_in_ready), 40'(1));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
